// File: rtl/bank_wbuffer_mp.sv
// ============================================================================
//  Module   : bank_wbuffer_mp
//  Purpose  : Bank write buffer. Holds xbar store data indexed by an upstream
//             allocated wbuffer id. Supports per-byte strobes, coalescing into
//             live entries, release-on-read, flush, an occupancy count and an
//             error pulse for bad ids or reads of invalid entries.
//  Ports    : clk_i / rst_n_i              clock, async active-low reset
//             wbuf_wr_*                    write request (id, data, strobes)
//             wbuf_rd_req_i/rd_id_i        read request, 1-cycle latency
//             wbuf_rd_release_i            free the entry at the read edge
//             wbuf_flush_i                 invalidate every entry
//             wbuf_rd_data_valid_o/..._o   registered read response
//             wbuf_err_o                   1-cycle error pulse
//             wbuf_count_o/full_o/empty_o  occupancy
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bank_wbuffer_mp #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 32,
    parameter int ID_WIDTH   = 5,
    parameter int STRB_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wbuf_wr_req_i,
    input  logic [ID_WIDTH-1:0]   wbuf_wr_id_i,
    input  logic [DATA_WIDTH-1:0] wbuf_wdata_i,
    input  logic [STRB_WIDTH-1:0] wbuf_wstrb_i,
    input  logic                  wbuf_rd_req_i,
    input  logic [ID_WIDTH-1:0]   wbuf_rd_id_i,
    input  logic                  wbuf_rd_release_i,
    input  logic                  wbuf_flush_i,
    output logic                  wbuf_rd_data_valid_o,
    output logic [DATA_WIDTH-1:0] wbuf_rd_data_o,
    output logic [STRB_WIDTH-1:0] wbuf_rd_mask_o,
    output logic                  wbuf_rd_hit_o,
    output logic                  wbuf_err_o,
    output logic [CNT_WIDTH-1:0]  wbuf_count_o,
    output logic                  wbuf_full_o,
    output logic                  wbuf_empty_o
);

    // One extra bit so DEPTH == 2**ID_WIDTH compares correctly.
    localparam logic [ID_WIDTH:0]  c_depth_ext = (ID_WIDTH + 1)'(DEPTH);
    localparam logic [CNT_WIDTH-1:0] c_depth_cnt = CNT_WIDTH'(DEPTH);

    logic [DATA_WIDTH-1:0] r_data [DEPTH];
    logic [STRB_WIDTH-1:0] r_mask [DEPTH];
    logic [DEPTH-1:0]      r_valid;
    logic [CNT_WIDTH-1:0]  r_count;

    logic                  r_rd_valid;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [STRB_WIDTH-1:0] r_rd_mask;
    logic                  r_rd_hit;
    logic                  r_err;

    logic                  w_wr_in_range;
    logic                  w_wr_do;
    logic                  w_wr_entry_valid;
    logic                  w_alloc;
    logic [DATA_WIDTH-1:0] w_old_data;
    logic [DATA_WIDTH-1:0] w_wr_data;
    logic [STRB_WIDTH-1:0] w_wr_mask;
    logic                  w_rd_in_range;
    logic                  w_rd_same;
    logic                  w_rd_hit;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [STRB_WIDTH-1:0] w_rd_mask;
    logic                  w_release;
    logic                  w_err;

    // ---------------- write path ----------------
    assign w_wr_in_range    = {1'b0, wbuf_wr_id_i} < c_depth_ext;
    assign w_wr_do          = wbuf_wr_req_i & w_wr_in_range & ~wbuf_flush_i;
    assign w_wr_entry_valid = w_wr_in_range & r_valid[wbuf_wr_id_i];
    assign w_alloc          = w_wr_do & ~w_wr_entry_valid;
    assign w_old_data       = r_data[wbuf_wr_id_i];

    // Allocation zeroes unstrobed bytes; coalescing keeps the old ones.
    always_comb begin
        w_wr_data = '0;
        for (int b = 0; b < STRB_WIDTH; b++) begin
            if (wbuf_wstrb_i[b])
                w_wr_data[8*b +: 8] = wbuf_wdata_i[8*b +: 8];
            else if (w_wr_entry_valid)
                w_wr_data[8*b +: 8] = w_old_data[8*b +: 8];
        end
    end

    assign w_wr_mask = w_wr_entry_valid ? (r_mask[wbuf_wr_id_i] | wbuf_wstrb_i)
                                        : wbuf_wstrb_i;

    // ---------------- read path ----------------
    // A same-cycle write to the read id is forwarded so the read sees merged data.
    assign w_rd_in_range = {1'b0, wbuf_rd_id_i} < c_depth_ext;
    assign w_rd_same     = w_wr_do & (wbuf_rd_id_i == wbuf_wr_id_i);
    assign w_rd_hit      = wbuf_rd_req_i & w_rd_in_range &
                           (r_valid[wbuf_rd_id_i] | w_rd_same);
    assign w_rd_data     = w_rd_same ? w_wr_data : r_data[wbuf_rd_id_i];
    assign w_rd_mask     = w_rd_same ? w_wr_mask : r_mask[wbuf_rd_id_i];
    assign w_release     = w_rd_hit & wbuf_rd_release_i;

    assign w_err = (wbuf_wr_req_i & ~w_wr_in_range) | (wbuf_rd_req_i & ~w_rd_hit);

    // ---------------- state ----------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_valid    <= '0;
            r_count    <= '0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_rd_mask  <= '0;
            r_rd_hit   <= 1'b0;
            r_err      <= 1'b0;
            for (int i = 0; i < DEPTH; i++) r_mask[i] <= '0;
        end else begin
            if (wbuf_flush_i) begin
                r_valid <= '0;
                for (int i = 0; i < DEPTH; i++) r_mask[i] <= '0;
            end else begin
                if (w_wr_do) begin
                    r_valid[wbuf_wr_id_i] <= 1'b1;
                    r_mask[wbuf_wr_id_i]  <= w_wr_mask;
                end
                // Later assignment wins: a same-id release cancels the write's allocate.
                if (w_release) begin
                    r_valid[wbuf_rd_id_i] <= 1'b0;
                    r_mask[wbuf_rd_id_i]  <= '0;
                end
            end

            if (wbuf_flush_i)
                r_count <= '0;
            else
                r_count <= r_count + CNT_WIDTH'(w_alloc) - CNT_WIDTH'(w_release);

            r_rd_valid <= wbuf_rd_req_i;
            r_rd_hit   <= w_rd_hit;
            r_rd_data  <= w_rd_hit ? w_rd_data : '0;
            r_rd_mask  <= w_rd_hit ? w_rd_mask : '0;
            r_err      <= w_err;
        end
    end

    // Data storage carries no reset; validity lives in r_valid / r_mask.
    always_ff @(posedge clk_i) begin
        if (w_wr_do)
            r_data[wbuf_wr_id_i] <= w_wr_data;
    end

    assign wbuf_rd_data_valid_o = r_rd_valid;
    assign wbuf_rd_data_o       = r_rd_data;
    assign wbuf_rd_mask_o       = r_rd_mask;
    assign wbuf_rd_hit_o        = r_rd_hit;
    assign wbuf_err_o           = r_err;
    assign wbuf_count_o         = r_count;
    assign wbuf_full_o          = (r_count == c_depth_cnt);
    assign wbuf_empty_o         = (r_count == '0);

endmodule

`default_nettype wire

// File: tb/tb_bank_wbuffer_mp.sv
// ============================================================================
//  Module   : tb_bank_wbuffer_mp
//  Purpose  : Self-checking bench for bank_wbuffer_mp (DEPTH 32 and DEPTH 24
//             instances) with directed scenarios and a randomized run against
//             an entry-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bank_wbuffer_mp;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DEPTH 32 instance ----------------
    logic         wr_req, rd_req, rd_release, flush;
    logic [4:0]   wr_id, rd_id;
    logic [127:0] wdata;
    logic [15:0]  wstrb;
    logic         rd_valid, rd_hit, err, full, empty;
    logic [127:0] rd_data;
    logic [15:0]  rd_mask;
    logic [5:0]   count;

    bank_wbuffer_mp dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .wbuf_wr_req_i(wr_req), .wbuf_wr_id_i(wr_id), .wbuf_wdata_i(wdata),
        .wbuf_wstrb_i(wstrb), .wbuf_rd_req_i(rd_req), .wbuf_rd_id_i(rd_id),
        .wbuf_rd_release_i(rd_release), .wbuf_flush_i(flush),
        .wbuf_rd_data_valid_o(rd_valid), .wbuf_rd_data_o(rd_data),
        .wbuf_rd_mask_o(rd_mask), .wbuf_rd_hit_o(rd_hit), .wbuf_err_o(err),
        .wbuf_count_o(count), .wbuf_full_o(full), .wbuf_empty_o(empty)
    );

    // ---------------- DEPTH 24 instance ----------------
    logic         b_wr_req, b_rd_req;
    logic [4:0]   b_wr_id, b_rd_id;
    logic         b_rd_valid, b_rd_hit, b_err, b_full, b_empty;
    logic [127:0] b_rd_data;
    logic [15:0]  b_rd_mask;
    logic [4:0]   b_count;

    bank_wbuffer_mp #(.DEPTH(24)) dut24 (
        .clk_i(clk), .rst_n_i(rst_n),
        .wbuf_wr_req_i(b_wr_req), .wbuf_wr_id_i(b_wr_id),
        .wbuf_wdata_i({4{32'hCAFE_F00D}}), .wbuf_wstrb_i(16'hFFFF),
        .wbuf_rd_req_i(b_rd_req), .wbuf_rd_id_i(b_rd_id),
        .wbuf_rd_release_i(1'b0), .wbuf_flush_i(1'b0),
        .wbuf_rd_data_valid_o(b_rd_valid), .wbuf_rd_data_o(b_rd_data),
        .wbuf_rd_mask_o(b_rd_mask), .wbuf_rd_hit_o(b_rd_hit), .wbuf_err_o(b_err),
        .wbuf_count_o(b_count), .wbuf_full_o(b_full), .wbuf_empty_o(b_empty)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model (DEPTH 32) ----------------
    logic [127:0] m_data  [32];
    logic [15:0]  m_mask  [32];
    logic         m_valid [32];
    logic         exp_valid, exp_hit, exp_err, exp_full, exp_empty;
    logic [127:0] exp_data;
    logic [15:0]  exp_mask;
    int           exp_count;

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_valid[i] = 1'b0;
            m_mask[i]  = '0;
            m_data[i]  = '0;
        end
    endtask

    task automatic idle();
        wr_req = 0; rd_req = 0; rd_release = 0; flush = 0;
        wr_id = 0; rd_id = 0; wdata = '0; wstrb = '0;
    endtask

    // Applies the current request to the model, then advances one clock and
    // stops 1 time unit after the edge where the response is visible.
    task automatic tick();
        logic hit;
        if (wr_req && !flush) begin
            for (int b = 0; b < 16; b++) begin
                if (wstrb[b])              m_data[wr_id][8*b +: 8] = wdata[8*b +: 8];
                else if (!m_valid[wr_id])  m_data[wr_id][8*b +: 8] = 8'h00;
            end
            m_mask[wr_id]  = m_valid[wr_id] ? (m_mask[wr_id] | wstrb) : wstrb;
            m_valid[wr_id] = 1'b1;
        end
        hit       = rd_req && m_valid[rd_id];
        exp_valid = rd_req;
        exp_hit   = hit;
        exp_data  = hit ? m_data[rd_id] : '0;
        exp_mask  = hit ? m_mask[rd_id] : '0;
        exp_err   = rd_req && !hit;
        if (hit && rd_release) begin
            m_valid[rd_id] = 1'b0;
            m_mask[rd_id]  = '0;
        end
        if (flush) begin
            for (int i = 0; i < 32; i++) begin
                m_valid[i] = 1'b0;
                m_mask[i]  = '0;
            end
        end
        exp_count = 0;
        for (int i = 0; i < 32; i++) exp_count += int'(m_valid[i]);
        exp_full  = (exp_count == 32);
        exp_empty = (exp_count == 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        b_wr_req = 0; b_rd_req = 0; b_wr_id = 0; b_rd_id = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 6'd0)  begin errors++; $display("FAIL reset_count act=%0d exp=0", count); end
        checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty act=%b exp=1", empty); end
        checks++; if ({rd_valid, rd_hit, err, full} !== 4'b0)
            begin errors++; $display("FAIL reset_flags act=%b exp=0000", {rd_valid, rd_hit, err, full}); end
        checks++; if ({rd_data, rd_mask} !== '0)
            begin errors++; $display("FAIL reset_data act=%h/%h exp=0", rd_data, rd_mask); end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        wr_req = 1; wr_id = 3; wdata = {16{8'hAA}}; wstrb = 16'hFFFF;
        tick();
        idle(); rd_req = 1; rd_id = 3;
        tick();
        idle();
        checks++; if ({rd_valid, rd_hit, err} !== 3'b110)
            begin errors++; $display("FAIL basic_flags act=%b exp=110", {rd_valid, rd_hit, err}); end
        checks++; if (rd_data !== {16{8'hAA}})
            begin errors++; $display("FAIL basic_data act=%h exp=%h", rd_data, {16{8'hAA}}); end
        checks++; if (rd_mask !== 16'hFFFF) begin errors++; $display("FAIL basic_mask act=%h exp=ffff", rd_mask); end
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL basic_count act=%0d exp=1", count); end
        tick();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_pulse act=%b exp=0", rd_valid); end
    endtask

    task automatic test_coalesce();
        wr_req = 1; wr_id = 5; wdata = {16{8'h11}}; wstrb = 16'h000F;
        tick();
        wdata = {16{8'h22}}; wstrb = 16'h00F0;
        tick();
        idle(); rd_req = 1; rd_id = 5;
        tick();
        idle();
        checks++; if (rd_data !== 128'h0000_0000_0000_0000_2222_2222_1111_1111)
            begin errors++; $display("FAIL coalesce_data act=%h exp=%h", rd_data, 128'h2222_2222_1111_1111); end
        checks++; if (rd_mask !== 16'h00FF) begin errors++; $display("FAIL coalesce_mask act=%h exp=00ff", rd_mask); end
        checks++; if (count !== 6'd2) begin errors++; $display("FAIL coalesce_count act=%0d exp=2", count); end
    endtask

    task automatic test_same_cycle_release();
        idle(); flush = 1;
        tick();
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL flush_count act=%0d exp=0", count); end
        idle();
        wr_req = 1; wr_id = 7; wdata = {4{32'h1234_5678}}; wstrb = 16'hFFFF;
        rd_req = 1; rd_id = 7; rd_release = 1;
        tick();
        idle();
        checks++; if ({rd_valid, rd_hit, err} !== 3'b110)
            begin errors++; $display("FAIL wrrel_flags act=%b exp=110", {rd_valid, rd_hit, err}); end
        checks++; if (rd_data !== {4{32'h1234_5678}})
            begin errors++; $display("FAIL wrrel_data act=%h exp=%h", rd_data, {4{32'h1234_5678}}); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL wrrel_count act=%0d exp=0", count); end
        rd_req = 1; rd_id = 7;
        tick();
        idle();
        checks++; if ({rd_hit, err} !== 2'b01 || rd_data !== '0)
            begin errors++; $display("FAIL wrrel_miss act=hit%b err%b data=%h exp=hit0 err1 data=0", rd_hit, err, rd_data); end
    endtask

    task automatic test_fill_flush();
        for (int i = 0; i < 32; i++) begin
            wr_req = 1; wr_id = 5'(i); wstrb = 16'hFFFF;
            wdata = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        idle();
        tick();
        checks++; if (full !== 1'b1 || count !== 6'd32)
            begin errors++; $display("FAIL fill_full act=full%b cnt%0d exp=full1 cnt32", full, count); end
        rd_req = 1; rd_id = 0; rd_release = 1;
        tick();
        idle();
        checks++; if (full !== 1'b0 || count !== 6'd31)
            begin errors++; $display("FAIL release_count act=full%b cnt%0d exp=full0 cnt31", full, count); end
        flush = 1; wr_req = 1; wr_id = 0; wdata = '1; wstrb = 16'hFFFF;
        tick();
        idle();
        checks++; if (count !== 6'd0 || empty !== 1'b1)
            begin errors++; $display("FAIL flushwr_count act=cnt%0d empty%b exp=cnt0 empty1", count, empty); end
        rd_req = 1; rd_id = 0;
        tick();
        idle();
        checks++; if ({rd_hit, err} !== 2'b01)
            begin errors++; $display("FAIL flushwr_miss act=hit%b err%b exp=hit0 err1", rd_hit, err); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wr_req     = ($urandom_range(0, 2) != 0);
            wr_id      = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
            wdata      = {$urandom, $urandom, $urandom, $urandom};
            wstrb      = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
            rd_req     = ($urandom_range(0, 1) != 0);
            rd_id      = ($urandom_range(0, 2) == 0) ? wr_id : 5'($urandom_range(0, 7));
            rd_release = ($urandom_range(0, 2) == 0);
            flush      = ($urandom_range(0, 24) == 0);
            tick();
            checks++;
            if ({rd_valid, rd_hit, err, full, empty} !== {exp_valid, exp_hit, exp_err, exp_full, exp_empty}) begin
                errors++;
                $display("FAIL rand_flags n=%0d act=%b exp=%b", n, {rd_valid, rd_hit, err, full, empty},
                         {exp_valid, exp_hit, exp_err, exp_full, exp_empty});
            end
            checks++;
            if (rd_data !== exp_data || rd_mask !== exp_mask) begin
                errors++;
                $display("FAIL rand_data n=%0d act=%h/%h exp=%h/%h", n, rd_data, rd_mask, exp_data, exp_mask);
            end
            checks++;
            if (int'(count) !== exp_count) begin
                errors++; $display("FAIL rand_count n=%0d act=%0d exp=%0d", n, count, exp_count);
            end
        end
        idle();
    endtask

    task automatic test_depth24();
        b_wr_req = 1; b_wr_id = 30;
        @(posedge clk); #1;
        b_wr_req = 0;
        checks++; if (b_err !== 1'b1 || b_count !== 5'd0)
            begin errors++; $display("FAIL d24_wr_oor act=err%b cnt%0d exp=err1 cnt0", b_err, b_count); end
        b_rd_req = 1; b_rd_id = 30;
        @(posedge clk); #1;
        b_rd_req = 0;
        checks++; if ({b_rd_valid, b_rd_hit, b_err} !== 3'b101 || b_rd_data !== '0)
            begin errors++; $display("FAIL d24_rd_oor act=%b data=%h exp=101 data=0", {b_rd_valid, b_rd_hit, b_err}, b_rd_data); end
        b_wr_req = 1; b_wr_id = 23;
        @(posedge clk); #1;
        b_wr_req = 0; b_rd_req = 1; b_rd_id = 23;
        checks++; if (b_err !== 1'b0 || b_count !== 5'd1)
            begin errors++; $display("FAIL d24_wr_last act=err%b cnt%0d exp=err0 cnt1", b_err, b_count); end
        @(posedge clk); #1;
        b_rd_req = 0;
        checks++; if ({b_rd_hit, b_err} !== 2'b10 || b_rd_data !== {4{32'hCAFE_F00D}} || b_rd_mask !== 16'hFFFF)
            begin errors++; $display("FAIL d24_rd_last act=hit%b err%b data=%h mask=%h exp=hit1 err0", b_rd_hit, b_err, b_rd_data, b_rd_mask); end
    endtask

    task automatic test_reset_midflight();
        wr_req = 1; wr_id = 9; wdata = '1; wstrb = 16'hFFFF;
        tick();
        idle(); rd_req = 1; rd_id = 9;
        #2 rst_n = 1'b0;   // asserted before the edge that would sample the read
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            idle();
            checks++;
            if ({rd_valid, rd_hit, err, full, empty} !== 5'b00001 || count !== 6'd0 || {rd_data, rd_mask} !== '0) begin
                errors++;
                $display("FAIL midreset k=%0d act=%b cnt%0d exp=00001 cnt0", k, {rd_valid, rd_hit, err, full, empty}, count);
            end
        end
        rst_n = 1'b1;
        model_reset();
        rd_req = 1; rd_id = 9;
        tick();
        idle();
        checks++; if ({rd_hit, err} !== 2'b01)
            begin errors++; $display("FAIL midreset_after act=hit%b err%b exp=hit0 err1", rd_hit, err); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_coalesce();
        test_same_cycle_release();
        test_fill_flush();
        test_random();
        test_depth24();
        test_reset_midflight();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/bank_wbuffer_mp.md
Name: bank_wbuffer_mp

Overview:
- Parametrised successor to the bank write buffer.
- Holds store data from the xbar, indexed by a wbuffer id allocated upstream.
- Adds per-byte strobes, write coalescing into live entries, entry valid tracking with release-on-read, flush, occupancy count and an invalid-access error pulse.
- Sits beside the HTU: written on xbar kickoff, read by the SRAM controller.

Parameters:
- DATA_WIDTH, 128, entry data width in bits; must be a multiple of 8.
- DEPTH, 32, number of entries; need not be a power of 2.
- ID_WIDTH, 5, width of the wr/rd id; 2^ID_WIDTH >= DEPTH.
- STRB_WIDTH, DATA_WIDTH/8, derived; byte-strobe width.
- CNT_WIDTH, $clog2(DEPTH+1), derived; occupancy counter width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  reset, asynchronous assert, active-low
- wbuf_wr_req_i  in  1  write strobe
- wbuf_wr_id_i  in  ID_WIDTH  write entry id
- wbuf_wdata_i  in  DATA_WIDTH  write data
- wbuf_wstrb_i  in  STRB_WIDTH  byte enables for the write
- wbuf_rd_req_i  in  1  read strobe
- wbuf_rd_id_i  in  ID_WIDTH  read entry id
- wbuf_rd_release_i  in  1  free the entry at the read edge; qualified by rd_req
- wbuf_flush_i  in  1  invalidate all entries
- wbuf_rd_data_valid_o  out  1  read response valid, 1-cycle pulse
- wbuf_rd_data_o  out  DATA_WIDTH  read data
- wbuf_rd_mask_o  out  STRB_WIDTH  accumulated byte mask of the entry read
- wbuf_rd_hit_o  out  1  read entry was valid
- wbuf_err_o  out  1  1-cycle pulse on out-of-range id or read of an invalid entry
- wbuf_count_o  out  CNT_WIDTH  number of valid entries
- wbuf_full_o  out  1  count == DEPTH
- wbuf_empty_o  out  1  count == 0

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - All valid bits, masks, count and registered outputs go to 0; empty_o = 1.
  - The data array is not reset.
  - A reset asserted mid-operation discards everything, including any read response in flight.
- Storage: per entry, data[DATA_WIDTH], mask[STRB_WIDTH] and valid.
- Write (wr_req=1, id < DEPTH, no flush):
  - Entry invalid (allocate): bytes with strb=1 take wdata, all other bytes become 0; mask = wstrb; valid = 1.
  - Entry valid (coalesce): only bytes with strb=1 are overwritten; mask |= wstrb; valid stays 1.
  - A write with wstrb = 0 to an invalid entry still allocates it, with mask 0.
- Read (rd_req=1):
  - The id is sampled at the edge; the response appears the next cycle, so latency is 1.
  - rd_data_valid_o = 1 for exactly one cycle per read request; back-to-back reads are supported every cycle.
  - rd_data_o / rd_mask_o show the entry contents; rd_hit_o shows the valid bit.
  - On a miss or out-of-range id: rd_data_o = 0, rd_mask_o = 0, rd_hit_o = 0, err_o = 1 in the response cycle.
- Release: rd_req & rd_release on a valid entry clears its valid bit and mask at that edge.
- Write and read to the same id in the same cycle:
  - The read returns the post-write (merged) data and mask, and rd_hit_o = 1.
  - If release is also set, the entry ends invalid and count is unchanged (the allocate and the release cancel).
- Write and read to different ids in the same cycle: both proceed independently.
- Flush:
  - Clears all valid bits and masks at the edge; count becomes 0 the next cycle.
  - A write in the flush cycle is dropped.
  - A read in the flush cycle returns pre-flush contents.
- Out-of-range write (id >= DEPTH): ignored, and err_o pulses the next cycle.
- err_o: a single pulse covers every error cause raised in the same cycle.
- Count:
  - +1 on an allocating write, −1 on the release of a valid entry.
  - Both in the same cycle gives a net of 0.
  - Registered, so it reflects operations one cycle later.
  - full_o and empty_o are derived from the registered count.
  - Count never exceeds DEPTH, because ids are unique per entry.
- No backpressure: the buffer always accepts requests. Upstream is responsible for not reusing a live id unless it intends to coalesce.

Test Plan:
- Reset, then write id 3 with wdata = 0xAA..AA and wstrb = 0xFFFF; read id 3 the next cycle → the cycle after: valid = 1, hit = 1, data = 0xAA..AA, mask = 0xFFFF, count = 1.
- Coalesce: write id 5 with strb = 0x000F, data = 0x11..11; then write id 5 with strb = 0x00F0, data = 0x22..22; read id 5 → bytes 0-3 = 0x11, bytes 4-7 = 0x22, all other bytes 0, mask = 0x00FF.
- Same-cycle write, read and release on id 7 (empty buffer) → response hit = 1 with the write data; count stays 0; a later read of id 7 gives hit = 0, err = 1, data = 0.
- Fill all 32 ids → full_o = 1 and count = 32; release id 0 → the next cycle full_o = 0 and count = 31; a flush combined with a write to id 0 in the same cycle → count = 0, empty_o = 1, and id 0 reads as a miss.
- DEPTH = 24 instance: write id 30 → err pulses, count is unchanged; read id 30 → err = 1, hit = 0.
- Assert rst_n_i low between a read request and its response → no rd_data_valid_o pulse; all outputs 0 and empty_o = 1 while reset is held.
